// File: rtl/spi_ram_mon_pkg.sv
// Shared types and constants for the SPI-slave RAM protocol monitor.
// Command encoding follows the two MSBs of din; error indices map to err_flags bits.
package spi_ram_mon_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        EXPECT = 2'b10,
        HOLD   = 2'b11
    } state_e;

    localparam int ERR_SEQ           = 0;
    localparam int ERR_TX_MISSING    = 1;
    localparam int ERR_TX_SPURIOUS   = 2;
    localparam int ERR_DATA_MISMATCH = 3;
    localparam int ERR_ADDR_RANGE    = 4;
    localparam int ERR_W             = 5;

    // Address width needed to index a shadow of the given depth (never zero).
    function automatic int shadow_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spi_ram_mon_shadow.sv
// Shadow copy of the RAM contents: one write port, asynchronous read,
// and a per-entry valid bit so unwritten locations are never data-checked.
module spi_ram_mon_shadow
    import spi_ram_mon_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DEPTH-1:0]  wsel;

    // One-hot write decode, so the valid vector has a single driver.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign wsel[gi] = we && (waddr == AW'(gi));
        end
    endgenerate

    always_comb begin
        valid_d = valid_q | wsel;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Asynchronous read: a same-cycle write is seen only after the edge.
    assign rdata  = mem_q[raddr];
    assign rvalid = valid_q[raddr];

endmodule

// File: rtl/spi_ram_protocol_monitor.sv
// Protocol monitor for the SPI-slave RAM interface: checks command order,
// tx_valid timing and read data against a shadow, with sticky/counted errors.
module spi_ram_protocol_monitor
    import spi_ram_mon_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int TX_LATENCY = 1,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] din,
    input  logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] dout,
    input  logic                 tx_valid,
    input  logic                 clr,
    output logic [ERR_W-1:0]     err_flags,
    output logic [CNT_W-1:0]     err_count,
    output logic                 err_pulse
);

    localparam int                 AW        = shadow_aw(MEM_DEPTH);
    localparam logic [ADDR_SIZE:0] DEPTH_LIM = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [2:0]         CNT_LOAD  = 3'(TX_LATENCY - 1);

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic                 addr_in_range;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             rearm_q, rearm_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             wr_addr_ok_q, wr_addr_ok_d;
    logic             rd_addr_ok_q, rd_addr_ok_d;
    logic [ERR_W-1:0] err_flags_q, err_flags_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_pulse_q, err_pulse_d;

    logic [ERR_W-1:0]     new_err;
    logic                 shadow_we;
    logic [ADDR_SIZE-1:0] shadow_rdata;
    logic                 shadow_rvalid;

    assign cmd           = cmd_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload       = din[ADDR_SIZE-1:0];
    assign addr_in_range = {1'b0, payload} < DEPTH_LIM;
    assign shadow_we     = rx_valid && (cmd == CMD_WR_DATA) && wr_addr_ok_q;

    spi_ram_mon_shadow #(
        .DATA_W (ADDR_SIZE),
        .DEPTH  (MEM_DEPTH),
        .AW     (AW)
    ) u_shadow (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (shadow_we),
        .waddr  (wr_addr_q),
        .wdata  (payload),
        .raddr  (rd_addr_q),
        .rdata  (shadow_rdata),
        .rvalid (shadow_rvalid)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rearm_d      = rearm_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_ok_d = wr_addr_ok_q;
        rd_addr_ok_d = rd_addr_ok_q;
        new_err      = '0;

        // Read-response timing and data check.
        case (state_q)
            IDLE: begin
                if (tx_valid) new_err[ERR_TX_SPURIOUS] = 1'b1;
            end
            WAIT: begin
                if (tx_valid) new_err[ERR_TX_SPURIOUS] = 1'b1;
                if (rx_valid) new_err[ERR_SEQ] = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = EXPECT;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            EXPECT: begin
                if (!tx_valid) begin
                    new_err[ERR_TX_MISSING] = 1'b1;
                end else if (shadow_rvalid && (dout != shadow_rdata)) begin
                    new_err[ERR_DATA_MISMATCH] = 1'b1;
                end
                state_d = HOLD;
            end
            default: begin
                if (tx_valid) new_err[ERR_TX_SPURIOUS] = 1'b1;
                state_d = rearm_q ? WAIT : IDLE;
                rearm_d = 1'b0;
            end
        endcase

        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    if (!addr_in_range) begin
                        new_err[ERR_ADDR_RANGE] = 1'b1;
                    end else begin
                        wr_addr_d    = payload[AW-1:0];
                        wr_addr_ok_d = 1'b1;
                    end
                end
                CMD_WR_DATA: begin
                    if (!wr_addr_ok_q) new_err[ERR_SEQ] = 1'b1;
                end
                CMD_RD_ADDR: begin
                    if (!addr_in_range) begin
                        new_err[ERR_ADDR_RANGE] = 1'b1;
                    end else begin
                        rd_addr_d    = payload[AW-1:0];
                        rd_addr_ok_d = 1'b1;
                    end
                end
                default: begin
                    if (!rd_addr_ok_q) begin
                        new_err[ERR_SEQ] = 1'b1;
                    end else if (state_q == EXPECT) begin
                        // Cannot start while the current check owns the next cycle; defer past HOLD.
                        rearm_d = 1'b1;
                        cnt_d   = CNT_LOAD;
                    end else if (state_q != WAIT) begin
                        if (TX_LATENCY == 1) begin
                            state_d = EXPECT;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
            endcase
        end

        err_pulse_d = |new_err;
        if (clr) begin
            err_flags_d = new_err;
            err_count_d = (|new_err) ? CNT_W'(1) : '0;
        end else begin
            err_flags_d = err_flags_q | new_err;
            if ((|new_err) && (err_count_q != '1)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end else begin
                err_count_d = err_count_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rearm_q      <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_addr_ok_q <= 1'b0;
            rd_addr_ok_q <= 1'b0;
            err_flags_q  <= '0;
            err_count_q  <= '0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rearm_q      <= rearm_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_ok_q <= wr_addr_ok_d;
            rd_addr_ok_q <= rd_addr_ok_d;
            err_flags_q  <= err_flags_d;
            err_count_q  <= err_count_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign err_flags = err_flags_q;
    assign err_count = err_count_q;
    assign err_pulse = err_pulse_q;

endmodule
